// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide unit.
// Holds op encodings, FSM state encoding, the default width and op helpers.
package ex_muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-to-muldiv request bundle plus stall and HI/LO result signals.
// master: issuing pipeline side; slave: the muldiv unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] RSdata_i;
  logic [WIDTH-1:0] RTdata_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic             div_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, RSdata_i, RTdata_i, flush_i,
    input  stall_o, busy_o, done_o, div_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, RSdata_i, RTdata_i, flush_i,
    output stall_o, busy_o, done_o, div_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Ports: div_i selects divide, acc_i/acc_o = {hi,lo} accumulator, opnd_i operand.
module ex_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    // Partial remainder shifted left by one, minus divisor;
    // the top bit is the borrow (remainder < divisor).
    trial = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    if (div_i) begin
      if (trial[WIDTH]) begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else if (acc_i[0]) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, WIDTH steps per op.
// Ports: clk_i, rst_i (async high), bus (slave): request, stall, HI/LO result.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic         clk_i,
  input logic         rst_i,
  ex_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dzo_q, dzo_d;

  logic               accept;
  logic               last;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  ex_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (op_is_div(op_q)),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  assign accept = bus.start_i & ~bus.flush_i;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // Magnitudes wrap at WIDTH bits, so the most negative value
  // stays itself; this makes MIN/-1 come out as MIN rem 0.
  assign rs_neg = op_is_signed(bus.op_i) & bus.RSdata_i[WIDTH-1];
  assign rt_neg = op_is_signed(bus.op_i) & bus.RTdata_i[WIDTH-1];
  assign rs_abs = rs_neg ? -bus.RSdata_i : bus.RSdata_i;
  assign rt_abs = rt_neg ? -bus.RTdata_i : bus.RTdata_i;

  // Remainder takes the dividend sign; it also restores the original
  // dividend on divide by zero, since the remainder is then |RS|.
  assign prod = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
  assign quo  = (neg_a_q ^ neg_b_q) ? -acc_step[WIDTH-1:0]
                                    : acc_step[WIDTH-1:0];
  assign rem  = neg_a_q ? -acc_step[2*WIDTH-1:WIDTH]
                        : acc_step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = '0;
          op_d    = bus.op_i;
          neg_a_d = rs_neg;
          neg_b_d = rt_neg;
          dz_d    = op_is_div(bus.op_i) & (bus.RTdata_i == '0);
          // Multiply: lower half holds multiplier, opnd multiplicand.
          // Divide: lower half holds dividend, opnd divisor.
          if (op_is_div(bus.op_i)) begin
            opnd_d = rt_abs;
            acc_d  = {{WIDTH{1'b0}}, rs_abs};
          end else begin
            opnd_d = rs_abs;
            acc_d  = {{WIDTH{1'b0}}, rt_abs};
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
            dzo_d   = dz_q;
            if (op_is_div(op_q)) begin
              hi_d = rem;
              lo_d = dz_q ? '1 : quo;
            end else begin
              hi_d = prod[2*WIDTH-1:WIDTH];
              lo_d = prod[WIDTH-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
    end
  end

  assign bus.busy_o     = (state_q == BUSY);
  assign bus.stall_o    = (state_q == BUSY) | accept;
  assign bus.done_o     = done_q;
  assign bus.div_zero_o = dzo_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide unit in the EX stage. It consumes the operands and op select that the ID/EX pipeline register drives out: RS/RT data plus a 2-bit op. It computes MULT/MULTU/DIV/DIVU into HI/LO over 32 iterations. While busy it back-pressures ID/EX and earlier stages through stall_o.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous active-high reset.
start_i  in  1  request valid from ID/EX this cycle.
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
RSdata_i  in  WIDTH  multiplicand / dividend.
RTdata_i  in  WIDTH  multiplier / divisor.
flush_i  in  1  abort in-flight operation (branch/exception flush).
stall_o  out  1  hold ID/EX and upstream stages.
busy_o  out  1  state is BUSY.
done_o  out  1  one-cycle pulse; HI/LO valid.
div_zero_o  out  1  pulses with done_o when a divide had divisor 0.
hi_o  out  WIDTH  HI register.
lo_o  out  WIDTH  LO register.

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE, counter 0, hi_o=lo_o=0, done_o=0, div_zero_o=0, internal operand registers 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start_i & !flush_i -> BUSY.
  - BUSY: counter==WIDTH-1 at the edge -> DONE; flush_i -> IDLE.
  - DONE: start_i & !flush_i -> BUSY (back-to-back); otherwise -> IDLE.
- Accept edge (E0): latch op, latch |RS| and |RT| for signed ops (raw values for unsigned ops), latch result-sign flags, set counter=0.
- Edges E1..E32: one radix-2 step each.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
- Edge E32: hi_o/lo_o written with sign-corrected results. done_o=1 for the following cycle (state DONE). Start to done is 33 edges.
- stall_o = (state==BUSY) | (state!=BUSY & start_i & !flush_i). It is combinational, so the instruction issuing the op is held in ID/EX until the unit finishes.
- busy_o = (state==BUSY).
- hi_o/lo_o change only at the completion edge or reset. They hold otherwise, including across flush.
- Multiply results: lo=product[WIDTH-1:0], hi=product[2W-1:WIDTH]. Signed product negated when the sign bits differ.
- Divide results: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out naturally from WIDTH-bit wrap of abs/negate.
- Divide by zero: no early exit, same 33-edge latency. Result lo=all ones, hi=RSdata (original signed value), div_zero_o=1 alongside done_o.
- flush_i:
  - In BUSY: -> IDLE next edge, no done_o, HI/LO untouched.
  - With start_i in the same cycle: flush wins and the start is dropped.
- start_i in BUSY: ignored (upstream is stalled, so it repeats).
- done_o and div_zero_o are registered, never combinational.

Decomposition:
- Shared package ex_muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encoding IDLE/BUSY/DONE;
  - WIDTH default constant.
- One natural sub-module, ex_muldiv_step: the combinational single-iteration datapath (add-shift or subtract-shift selected by op). The FSM, counter and sign correction stay in ex_muldiv.

Test Plan:
- MULT RS=0xFFFFFFFD (-3), RT=7 -> done_o exactly 33 edges after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall_o high for the accept cycle and all 32 BUSY cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; div_zero_o=0.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> after 33 edges lo=0xFFFFFFFF, hi=5, div_zero_o=1 for one cycle together with done_o.
- Prior result hi=1, lo=2. Start MULT, assert flush_i at BUSY cycle 10 -> IDLE next edge, done_o never pulses, hi=1, lo=2, stall_o drops.
- Back-to-back:
  - start_i held in DONE cycle -> second op enters BUSY with no IDLE gap and completes after 33 more edges.
  - rst_i asserted mid-BUSY -> outputs 0 immediately, asynchronously and without waiting for a clock edge.
